// File: rtl/bcd_serial_add_ctrl_if.sv
// Bundle between the operand source, the serial BCD add controller and the
// shared external digit adder.
interface bcd_serial_add_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = 4 * DIGITS;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_ci;
    logic [3:0]   add_result;
    logic         add_cout;

    // Environment side: operand source plus the external digit adder.
    modport master (
        output start, op_a, op_b, cin, add_result, add_cout,
        input  busy, done, sum, cout, err, add_a, add_b, add_ci
    );

    modport slave (
        input  start, op_a, op_b, cin, add_result, add_cout,
        output busy, done, sum, cout, err, add_a, add_b, add_ci
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder sequencer: feeds one digit pair per clock to a
// shared external BCD digit adder, LSD first, and assembles the sum.
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    bcd_serial_add_ctrl_if.slave bus
);
    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             err_q;
    logic             bad_c;

    // Any operand digit above 9 rejects the request.
    always_comb begin
        bad_c = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((bus.op_a[4*i +: 4] > 4'd9) || (bus.op_b[4*i +: 4] > 4'd9)) begin
                bad_c = 1'b1;
            end
        end
    end

    // Sequencer. Shift registers fill with zeros and the carry is cleared on
    // completion, so the adder inputs read as 0 whenever not in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    sum_q   <= (sum_q >> 4) | (W'(bus.add_result) << (W - 4));
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    carry_q <= bus.add_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIGITS - 1)) begin
                        cout_q  <= bus.add_cout;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    // The edge ending the done cycle can already take a new start.
                    if (state_q == S_DONE) begin
                        state_q <= S_IDLE;
                    end
                    if (bus.start) begin
                        cnt_q  <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        if (bad_c) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            a_q     <= '0;
                            b_q     <= '0;
                            carry_q <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            a_q     <= bus.op_a;
                            b_q     <= bus.op_b;
                            carry_q <= bus.cin;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.sum    = sum_q;
    assign bus.cout   = cout_q;
    assign bus.err    = err_q;
    assign bus.add_a  = a_q[3:0];
    assign bus.add_b  = b_q[3:0];
    assign bus.add_ci = carry_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench: ideal digit adder, decimal-arithmetic reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_bcd_serial_add_ctrl;
    localparam int unsigned D = 4;
    localparam int unsigned W = 4 * D;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_serial_add_ctrl_if #(.DIGITS(D)) bus ();
    bcd_serial_add_ctrl #(.DIGITS(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Ideal combinational BCD digit adder.
    logic [4:0] dsum;
    always_comb begin
        dsum = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_ci);
        if (dsum > 5'd9) begin
            bus.add_result = 4'(dsum - 5'd10);
            bus.add_cout   = 1'b1;
        end else begin
            bus.add_result = dsum[3:0];
            bus.add_cout   = 1'b0;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic bit isbcd(input logic [W-1:0] v);
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model: whole-number decimal addition with a cycle countdown.
    int           m_left = 0;
    bit           m_busy = 0, m_done = 0, m_err = 0, m_cout = 0, m_cin = 0, m_rc = 0;
    logic [W-1:0] m_sum = '0, m_res = '0, m_a = '0, m_b = '0;
    int           total;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_busy = 0; m_done = 0; m_err = 0; m_cout = 0;
            m_sum  = '0; m_a = '0; m_b = '0; m_cin = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_sum = m_res; m_cout = m_rc;
                end
            end else if (bus.start) begin
                m_sum = '0; m_cout = 0;
                if (!isbcd(bus.op_a) || !isbcd(bus.op_b)) begin
                    m_err = 1; m_done = 1;
                end else begin
                    total  = bcd2int(bus.op_a) + bcd2int(bus.op_b) + int'(bus.cin);
                    m_res  = int2bcd(total % pow10(D));
                    m_rc   = (total >= pow10(D));
                    m_err  = 0; m_busy = 1; m_left = D;
                    m_a    = bus.op_a; m_b = bus.op_b; m_cin = bus.cin;
                end
            end
        end
    end

    // Carry into digit k follows from the low k digits of the operands.
    function automatic bit carry_in(input int k);
        int p = pow10(k);
        return ((bcd2int(m_a) % p) + (bcd2int(m_b) % p) + int'(m_cin)) >= p;
    endfunction

    always @(negedge clk) begin
        int k;
        k = D - m_left;
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("err",  32'(bus.err),  32'(m_err));
        chk("cout", 32'(bus.cout), 32'(m_cout));
        if (!m_busy) chk("sum", 32'(bus.sum), 32'(m_sum));
        if (m_busy) begin
            chk("add_a",  32'(bus.add_a),  32'(m_a[4*k +: 4]));
            chk("add_b",  32'(bus.add_b),  32'(m_b[4*k +: 4]));
            chk("add_ci", 32'(bus.add_ci), 32'(carry_in(k)));
        end else begin
            chk("add_a_idle",  32'(bus.add_a),  32'd0);
            chk("add_b_idle",  32'(bus.add_b),  32'd0);
            chk("add_ci_idle", 32'(bus.add_ci), 32'd0);
        end
    end

    logic [3:0] aq[$];

    // Issue one request; report the edge (relative to acceptance) where done rose.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit ci,
                          input bit imm, output int edge_n, output bit saw_busy);
        if (!imm) begin
            @(posedge clk);
            #2;
        end
        bus.op_a = a; bus.op_b = b; bus.cin = ci; bus.start = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0; bus.op_a = ~a; bus.op_b = ~b; bus.cin = ~ci;
        aq.delete();
        edge_n   = -1;
        saw_busy = 1'b0;
        for (int i = 1; i <= 20 && edge_n < 0; i++) begin
            @(negedge clk);
            if (bus.busy) begin
                saw_busy = 1'b1;
                aq.push_back(bus.add_a);
            end
            if (bus.done) edge_n = i - 1;
        end
        chk("done_seen", 32'(edge_n >= 0), 32'd1);
    endtask

    int e;
    bit sb;
    int npulse;
    int pe[$];
    bit saw_done;

    initial begin
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0;
        #7;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'd0);
        chk("rst_err",  32'(bus.err),  32'd0);
        chk("rst_add",  32'({bus.add_a, bus.add_b, bus.add_ci}), 32'd0);
        #5 rst_n = 1'b1;

        // Basic add, digit order and latency.
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, e, sb);
        chk("s1_edge", 32'(e), 32'd4);
        chk("s1_sum",  32'(bus.sum), 32'h6912);
        chk("s1_cout", 32'(bus.cout), 32'd0);
        chk("s1_err",  32'(bus.err), 32'd0);
        chk("s1_nseq", 32'(aq.size()), 32'd4);
        if (aq.size() == 4) begin
            chk("s1_seq0", 32'(aq[0]), 32'd4);
            chk("s1_seq1", 32'(aq[1]), 32'd3);
            chk("s1_seq2", 32'(aq[2]), 32'd2);
            chk("s1_seq3", 32'(aq[3]), 32'd1);
        end

        // Full carry ripple and wrap; carry in.
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, e, sb);
        chk("s2a_sum",  32'(bus.sum), 32'h0000);
        chk("s2a_cout", 32'(bus.cout), 32'd1);
        run_op(16'h0999, 16'h0000, 1'b1, 1'b0, e, sb);
        chk("s2b_sum",  32'(bus.sum), 32'h1000);
        chk("s2b_cout", 32'(bus.cout), 32'd0);

        // Non-BCD operand, then a clean request clears err.
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, e, sb);
        chk("s3_edge", 32'(e), 32'd0);
        chk("s3_err",  32'(bus.err), 32'd1);
        chk("s3_sum",  32'(bus.sum), 32'd0);
        chk("s3_cout", 32'(bus.cout), 32'd0);
        chk("s3_busy", 32'(sb), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, e, sb);
        chk("s3_clr_err", 32'(bus.err), 32'd0);
        chk("s3_clr_sum", 32'(bus.sum), 32'h0002);

        // start held for 12 cycles.
        @(posedge clk);
        #2;
        bus.op_a = 16'h0001; bus.op_b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
        npulse = 0;
        pe.delete();
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done) begin
                npulse++;
                pe.push_back(i - 1);
                chk("s4_sum", 32'(bus.sum), 32'h0002);
            end
        end
        bus.start = 1'b0;
        chk("s4_pulses", 32'(npulse), 32'd2);
        if (pe.size() == 2) begin
            chk("s4_edge0", 32'(pe[0]), 32'd4);
            chk("s4_edge1", 32'(pe[1]), 32'd9);
        end
        repeat (10) @(negedge clk);

        // Reset mid-run.
        @(posedge clk);
        #2;
        bus.op_a = 16'h5555; bus.op_b = 16'h5555; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_busy", 32'(bus.busy), 32'd0);
        chk("s5_done", 32'(bus.done), 32'd0);
        chk("s5_sum",  32'(bus.sum),  32'd0);
        chk("s5_cout", 32'(bus.cout), 32'd0);
        chk("s5_err",  32'(bus.err),  32'd0);
        chk("s5_add",  32'({bus.add_a, bus.add_b, bus.add_ci}), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        chk("s5_no_done", 32'(saw_done), 32'd0);
        run_op(16'h0005, 16'h0005, 1'b0, 1'b0, e, sb);
        chk("s5_sum2",  32'(bus.sum), 32'h0010);
        chk("s5_cout2", 32'(bus.cout), 32'd0);

        // Back-to-back at the earliest accepting edge.
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, e, sb);
        chk("s6a_sum", 32'(bus.sum), 32'h0001);
        run_op(16'h9999, 16'h9999, 1'b1, 1'b1, e, sb);
        chk("s6b_edge", 32'(e), 32'd4);
        chk("s6b_sum",  32'(bus.sum), 32'h9999);
        chk("s6b_cout", 32'(bus.cout), 32'd1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
